// File: rtl/fp_add_norm_pack.sv
// Normalise, round-to-nearest-even and pack the binary32 adder result; 2-cycle latency.
// A stalled output (out_valid & ~out_ready) freezes both stages and drops in_ready.
module fp_add_norm_pack #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] Z,
  input  logic [4:0]       C,
  input  logic [EXP_W-1:0] ZE,
  input  logic             E,
  input  logic             AS,
  input  logic             BS,
  input  logic             ZS,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      F,
  output logic             ovf,
  output logic             unf,
  output logic             zero
);

  localparam logic signed [EXP_W+1:0] ONE_X  = 1;
  localparam logic signed [EXP_W+1:0] ZERO_X = 0;
  localparam logic signed [EXP_W+1:0] EMAX_X = (1 << EXP_W) - 1;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage 1: normalise. Only the 23-bit fraction is kept; the hidden bit is implicit.
  logic                    n1_zero, n1_sign, n1_g;
  logic [MAN_W-2:0]        n1_frac;
  logic signed [EXP_W+1:0] n1_exp, ze_x, c_x;

  assign ze_x = $signed({2'b00, ZE});
  assign c_x  = $signed({{(EXP_W-3){1'b0}}, C});

  always_comb begin
    n1_zero = ~E & ((C >= 5'd24) | (Z == '0));
    n1_sign = ZS;
    n1_g    = 1'b0;
    n1_frac = '0;
    n1_exp  = ZERO_X;
    if (n1_zero) begin
      n1_sign = AS & BS;
    end else if (E) begin
      n1_frac = Z[MAN_W-1:1];
      n1_g    = Z[0];
      n1_exp  = ze_x + ONE_X;
    end else begin
      n1_frac = Z[MAN_W-2:0] << C;
      n1_exp  = ze_x - c_x;
    end
  end

  logic                    s1_vld, s1_zero, s1_sign, s1_g;
  logic [MAN_W-2:0]        s1_frac;
  logic signed [EXP_W+1:0] s1_exp;

  // Stage 2: a carry out of the fraction sum means the mantissa wrapped to 2^24,
  // leaving the fraction at zero and bumping the exponent.
  logic [MAN_W-1:0]        rsum;
  logic signed [EXP_W+1:0] r_exp;
  logic [31:0]             n2_f;
  logic                    n2_ovf, n2_unf, n2_zero;

  always_comb begin
    rsum    = {1'b0, s1_frac} + {{(MAN_W-1){1'b0}}, s1_g & s1_frac[0]};
    r_exp   = rsum[MAN_W-1] ? s1_exp + ONE_X : s1_exp;
    n2_f    = {s1_sign, r_exp[EXP_W-1:0], rsum[MAN_W-2:0]};
    n2_ovf  = 1'b0;
    n2_unf  = 1'b0;
    n2_zero = 1'b0;
    if (s1_zero) begin
      n2_f    = {s1_sign, 31'b0};
      n2_zero = 1'b1;
    end else if (r_exp <= ZERO_X) begin
      n2_f    = {s1_sign, 31'b0};
      n2_unf  = 1'b1;
      n2_zero = 1'b1;
    end else if (r_exp >= EMAX_X) begin
      n2_f    = {s1_sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
      n2_ovf  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sign   <= 1'b0;
      s1_g      <= 1'b0;
      s1_frac   <= '0;
      s1_exp    <= ZERO_X;
      out_valid <= 1'b0;
      F         <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      s1_vld    <= in_valid;
      s1_zero   <= n1_zero;
      s1_sign   <= n1_sign;
      s1_g      <= n1_g;
      s1_frac   <= n1_frac;
      s1_exp    <= n1_exp;
      out_valid <= s1_vld;
      F         <= n2_f;
      ovf       <= n2_ovf;
      unf       <= n2_unf;
      zero      <= n2_zero;
    end
  end

endmodule

// File: tb/tb_fp_add_norm_pack.sv
// Scoreboard bench for fp_add_norm_pack: directed vectors, backpressure, random stream, mid-stream reset.
module tb_fp_add_norm_pack;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        E = 1'b0, AS = 1'b0, BS = 1'b0, ZS = 1'b0;
  logic [23:0] Z = '0;
  logic [4:0]  C = '0;
  logic [7:0]  ZE = '0;
  logic        in_ready, out_valid, ovf, unf, zero;
  logic [31:0] F;

  logic [34:0] sb[$];
  int          n_cmp = 0, n_err = 0;
  bit          mon_en = 1'b1, rnd_done = 1'b0;

  fp_add_norm_pack #(.MAN_W(24), .EXP_W(8)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .Z(Z), .C(C), .ZE(ZE), .E(E), .AS(AS), .BS(BS), .ZS(ZS),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .ovf(ovf), .unf(unf), .zero(zero)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Independent reference: locate the leading one of {E,Z} directly, ignoring C.
  function automatic logic [34:0] model(input logic [23:0] z, input logic [4:0] c,
                                        input logic [7:0] ze, input logic e,
                                        input logic as_, input logic bs_, input logic zs_);
    logic [24:0] v, mant;
    logic        g;
    int          p, ex;
    v = {e, z};
    if (!e && (c >= 5'd24 || z == 24'd0))
      return {as_ & bs_, 31'b0, 3'b001};
    p = -1;
    for (int i = 0; i < 25; i++) if (v[i]) p = i;
    ex = int'(ze) + p - 23;
    if (p == 24) begin
      mant = v >> 1;
      g    = v[0];
    end else begin
      mant = v << (23 - p);
      g    = 1'b0;
    end
    if (g && mant[0]) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      ex++;
    end
    if (ex <= 0)   return {zs_, 31'b0, 3'b011};
    if (ex >= 255) return {zs_, 8'hFF, 23'b0, 3'b100};
    return {zs_, ex[7:0], mant[22:0], 3'b000};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [23:0] z, input logic [4:0] c, input logic [7:0] ze,
                      input logic e, input logic as_, input logic bs_, input logic zs_,
                      input logic [34:0] expv);
    int t = 0;
    Z = z; C = c; ZE = ze; E = e; AS = as_; BS = bs_; ZS = zs_;
    in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) chk("accept_timeout", {34'b0, in_ready}, 35'd1);
    else sb.push_back(expv);
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk(tag, 35'(sb.size()), 35'd0);
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (mon_en && !RST && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 35'(sb.size()), 35'd1);
      else chk("result", {F, ovf, unf, zero}, sb.pop_front());
    end
  end

  logic [31:0] held;

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out", {F, ovf, unf, zero}, 35'd0);
    chk("rst_vld", {34'b0, out_valid}, 35'd0);
    chk("rst_rdy", {34'b0, in_ready}, 35'd1);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rdy_after_rst", {34'b0, in_ready}, 35'd1);
    @(posedge CLK);
    #1;

    // Directed vectors
    send(24'h000000, 5'd0,  8'd127, 1'b1, 1'b0, 1'b0, 1'b0, {32'h40000000, 3'b000});
    send(24'h400000, 5'd1,  8'd127, 1'b0, 1'b0, 1'b0, 1'b0, {32'h3F000000, 3'b000});
    send(24'hFFFFFF, 5'd0,  8'd127, 1'b1, 1'b0, 1'b0, 1'b0, {32'h40800000, 3'b000});
    send(24'h000000, 5'd0,  8'd254, 1'b1, 1'b1, 1'b1, 1'b1, {32'hFF800000, 3'b100});
    send(24'h000000, 5'd24, 8'd127, 1'b0, 1'b0, 1'b1, 1'b1, {32'h00000000, 3'b001});
    send(24'h000000, 5'd24, 8'd90,  1'b0, 1'b1, 1'b1, 1'b0, {32'h80000000, 3'b001});
    send(24'h000100, 5'd15, 8'd10,  1'b0, 1'b0, 1'b0, 1'b1, {32'h80000000, 3'b011});
    send(24'h000001, 5'd0,  8'd127, 1'b1, 1'b0, 1'b0, 1'b0, {32'h40000000, 3'b000});
    send(24'h000003, 5'd0,  8'd127, 1'b1, 1'b0, 1'b0, 1'b0, {32'h40000002, 3'b000});
    send(24'h800000, 5'd0,  8'd0,   1'b0, 1'b0, 1'b0, 1'b0, {32'h00000000, 3'b011});
    send(24'hFFFFFF, 5'd0,  8'd254, 1'b0, 1'b0, 1'b0, 1'b0, {32'h7F7FFFFF, 3'b000});
    drain("drain_directed");

    // Backpressure: out_ready low for 3 cycles while a 4-bundle stream is in flight
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(24'h5A5A5A, 5'd0, 8'(100 + k), 1'b1, 1'b0, 1'b0, 1'(k),
               model(24'h5A5A5A, 5'd0, 8'(100 + k), 1'b1, 1'b0, 1'b0, 1'(k)));
      end
      begin
        repeat (2) @(posedge CLK);
        #1 out_ready = 1'b0;
        @(negedge CLK);
        held = F;
        chk("stall_vld", {34'b0, out_valid}, 35'd1);
        chk("stall_rdy", {34'b0, in_ready}, 35'd0);
        repeat (2) begin
          @(negedge CLK);
          chk("stall_rdy", {34'b0, in_ready}, 35'd0);
          chk("stall_vld", {34'b0, out_valid}, 35'd1);
          chk("stall_hold", {3'b0, F}, {3'b0, held});
        end
        @(posedge CLK);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Random stream with random backpressure
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          logic [23:0] rz;
          logic [4:0]  rc;
          logic [7:0]  rze;
          logic        re, ras, rbs, rzs;
          int          p;
          re = 1'($urandom_range(0, 1));
          if (re) begin
            rz = 24'($urandom);
            rc = 5'd24;
            for (int i = 0; i < 24; i++) if (rz[i]) rc = 5'(23 - i);
          end else begin
            p  = int'($urandom_range(0, 23));
            rz = 24'(($urandom & ((32'd1 << p) - 32'd1)) | (32'd1 << p));
            rc = 5'(23 - p);
            if ($urandom_range(0, 9) == 0) begin
              rz = '0;
              rc = 5'd24;
            end
          end
          rze = 8'($urandom_range(0, 255));
          ras = 1'($urandom_range(0, 1));
          rbs = 1'($urandom_range(0, 1));
          rzs = 1'($urandom_range(0, 1));
          send(rz, rc, rze, re, ras, rbs, rzs, model(rz, rc, rze, re, ras, rbs, rzs));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge CLK);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random");

    // Reset with both stages occupied
    mon_en = 1'b0;
    Z = 24'h000000; C = 5'd0; ZE = 8'd127; E = 1'b1; ZS = 1'b0;
    in_valid = 1'b1;
    @(posedge CLK);
    #1 ZE = 8'd130;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    chk("prerst_vld", {34'b0, out_valid}, 35'd1);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("midrst_vld", {34'b0, out_valid}, 35'd0);
    chk("midrst_out", {F, ovf, unf, zero}, 35'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("postrst_vld", {34'b0, out_valid}, 35'd0);
      chk("postrst_rdy", {34'b0, in_ready}, 35'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_add_norm_pack.md
Name: fp_add_norm_pack

Overview:
- Final two stages of the pipelined single-precision floating-point adder used by the radix-3^2 butterflies.
- Consumes the registered post-addition bundle from the preceding pipeline buffer: mantissa sum, leading-zero count, provisional exponent, carry flag and signs.
- Stage 1 normalises; stage 2 rounds (nearest-even) and packs an IEEE-754 binary32 word with status flags.
- Carries a valid/ready handshake so the adder pipeline can be stalled by the twiddle-multiply or commutator stages downstream.

Parameters:
- MAN_W, 24: mantissa width including hidden bit. Only 24 is supported.
- EXP_W, 8: exponent width. Only 8 is supported.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous active-high reset
- in_valid  in  1  input bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- Z  in  24  mantissa sum magnitude, hidden-bit position = bit 23
- C  in  5  leading-zero count of Z (0..24; 24 = Z is zero)
- ZE  in  8  provisional exponent (larger operand's biased exponent)
- E  in  1  carry-out of mantissa add (sum bit 24)
- AS  in  1  sign of operand A
- BS  in  1  sign of operand B
- ZS  in  1  provisional result sign
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- F  out  32  packed binary32 result
- ovf  out  1  result overflowed to infinity
- unf  out  1  result underflowed and was flushed to zero
- zero  out  1  result is ±0

Behaviour:
- Reset: RST is synchronous, active-high, sampled on the rising edge of CLK.
  - Clears both stage valid bits and every output register.
  - Reset values: out_valid=0, F=0, ovf=0, unf=0, zero=0.
  - in_ready reads 1 in the cycle after reset.
  - RST mid-operation discards all in-flight bundles; no partial output is ever produced.
- Handshake and stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - When stall=0, both stages advance together. Stage 1 captures the input (its valid = in_valid); stage 2 captures stage 1.
  - When stall=1, all stage registers hold, and the inputs are ignored.
  - A bundle is accepted when in_valid & in_ready. Its result appears on out_valid 2 accepted-advance cycles later.
  - Throughput is one result per cycle when out_ready is held at 1.
  - Bubbles (in_valid=0) propagate as out_valid=0. Data registers may update on bubbles; F is don't-care while out_valid=0.
- Stage 1, normalise (internal exponent is 10-bit signed):
  - Zero case, when E=0 and (C>=24 or Z==0):
    - zero_r=1, exponent and mantissa forced to 0.
    - sign_r = AS & BS (round-to-nearest zero rule); ZS is ignored.
  - Carry case, when E=1:
    - m = {1, Z[23:1]}, guard = Z[0], exp = ZE+1.
  - Normal case, when E=0 and C<24:
    - m = Z << C, guard = 0, exp = ZE − C.
    - This path is exact; no rounding is needed.
  - In all non-zero cases sign_r = ZS.
  - Upstream sticky bits are not available. Rounding uses guard only, so a guard bit of 1 is treated as an exact tie.
- Stage 2, round and pack:
  - Round-to-nearest-even: increment m when guard & m[0].
  - If the increment wraps m to 2^24, then m = 0x800000 and exp = exp+1.
  - Underflow, when exp <= 0 and the result is not the zero case:
    - F = {sign, 31'b0}, unf=1, zero=1.
    - No subnormal outputs are produced.
  - Overflow, when exp >= 255 (including after the rounding carry):
    - F = {sign, 8'hFF, 23'b0}, ovf=1.
  - Otherwise F = {sign, exp[7:0], m[22:0]}.
  - zero=1 only for the zero case or underflow. ovf and unf are mutually exclusive.
- Flags are registered with F and are valid only while out_valid=1.
- Inputs of NaN or infinity are not handled here; special-value bypass is done by the exponent-compare stage upstream.

Test Plan:
- Carry path (1.0+1.0): Z=0x000000, E=1, C=0, ZE=127, ZS=0 -> out_valid after 2 cycles, F=0x40000000, flags all 0.
- Normalise path (1.5−1.0): Z=0x400000, E=0, C=1, ZE=127, ZS=0 -> F=0x3F000000.
- Round-up with exponent bump: Z=0xFFFFFF, E=1, ZE=127, ZS=0 -> F=0x40800000.
- Overflow: Z=0x000000, E=1, ZE=254, ZS=1 -> F=0xFF800000, ovf=1.
- Cancellation: Z=0, C=24, E=0, AS=0, BS=1 -> F=0x00000000, zero=1.
- Underflow: Z=0x000100, C=15, E=0, ZE=10, ZS=1 -> F=0x80000000, unf=1, zero=1.
- Backpressure: stream 4 bundles back-to-back with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall; F and out_valid held stable; no bundle lost or duplicated; results in order.
- Reset mid-stream: assert RST while both stages are valid -> next cycle out_valid=0, F=0.
